exo1_dot_acc: RTL and testbench

EXO1_DOT_ACC -- requirements
Module: exo1_dot_acc

---
 rtl/exo1_dot_acc_pkg.sv | 15 +
 rtl/exo1_dot_acc_add.sv | 37 +++
 rtl/exo1_dot_acc.sv | 122 ++++++++++++
 tb/tb_exo1_dot_acc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/exo1_dot_acc_pkg.sv
// exo1_dot_acc_pkg: state encoding and default widths shared by
// the dot-product accumulator and its adder.
package exo1_dot_acc_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/exo1_dot_acc_add.sv
// exo1_dot_acc_add: signed add with overflow detect; clamps to the
// signed limits when EXO1_DOT_ACC_SAT_EN is defined, wraps otherwise.
module exo1_dot_acc_add
    import exo1_dot_acc_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] i_a,
    input  logic [ACC_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_ovf
);

    logic [ACC_WIDTH-1:0] w_raw;
    logic                 w_ovf;

    assign w_raw = i_a + i_b;

    // Overflow only when both operands share a sign the sum lacks.
    assign w_ovf = (i_a[ACC_WIDTH-1] == i_b[ACC_WIDTH-1])
                && (w_raw[ACC_WIDTH-1] != i_a[ACC_WIDTH-1]);

    assign o_ovf = w_ovf;

`ifdef EXO1_DOT_ACC_SAT_EN
    logic [ACC_WIDTH-1:0] w_max;
    logic [ACC_WIDTH-1:0] w_min;

    assign w_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    assign w_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    assign o_sum = w_ovf ? (i_a[ACC_WIDTH-1] ? w_min : w_max)
                         : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/exo1_dot_acc.sv
// exo1_dot_acc: accumulates signed product beats into a dot product
// and holds the result until consumed. Saturation: EXO1_DOT_ACC_SAT_EN.
module exo1_dot_acc
    import exo1_dot_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [CNT_WIDTH-1:0]         out_count,
    output logic                         out_ovf,
    input  logic                         out_ready
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE =
        {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_next;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_ovf;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic [CNT_WIDTH-1:0] r_out_count;
    logic                 r_out_ovf;

    logic                 w_accept;
    logic                 w_consume;
    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_add_ovf;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_ovf_nxt;

    assign in_ready  = ce && (r_state != S_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = ce && out_ready && (r_state == S_HOLD);
    assign w_ext     = ACC_WIDTH'(in_data);

    exo1_dot_acc_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // First beat of a frame loads rather than adds.
    always_comb begin
        w_acc_nxt = w_sum;
        w_cnt_nxt = (&r_count) ? r_count : r_count + CNT_ONE;
        w_ovf_nxt = r_ovf | w_add_ovf;
        if (r_state == S_IDLE) begin
            w_acc_nxt = w_ext;
            w_cnt_nxt = CNT_ONE;
            w_ovf_nxt = 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_next = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (w_consume) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            if (in_last) begin
                r_out_data  <= w_acc_nxt;
                r_out_count <= w_cnt_nxt;
                r_out_ovf   <= w_ovf_nxt;
            end
        end
    end

    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_exo1_dot_acc.sv
// tb_exo1_dot_acc: directed frames checked against an arithmetic
// frame model every cycle, plus literal expected results.
module tb_exo1_dot_acc;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam longint AMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (AW-1));
    localparam longint CMAX = (longint'(1) <<< CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;
    logic          out_ovf;
    logic          out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exo1_dot_acc #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Frame model: plain integer arithmetic with range test per add.
    bit     m_inframe = 0;
    bit     m_hold = 0;
    longint m_acc = 0;
    longint m_cnt = 0;
    bit     m_ovf = 0;
    longint e_data = 0;
    longint e_cnt = 0;
    bit     e_ovf = 0;

    function automatic longint add_model(input longint a, input longint b,
                                         inout bit ovf);
        longint s;
        s = a + b;
        if (s > AMAX || s < AMIN) begin
            ovf = 1;
`ifdef EXO1_DOT_ACC_SAT_EN
            s = (s > AMAX) ? AMAX : AMIN;
`else
            if (s > AMAX) s -= (longint'(1) <<< AW);
            else s += (longint'(1) <<< AW);
`endif
        end
        return s;
    endfunction

    always @(posedge clk) begin
        longint x;
        x = longint'($signed(in_data));
        if (reset) begin
            m_inframe = 0; m_hold = 0;
            m_acc = 0; m_cnt = 0; m_ovf = 0;
        end else if (ce) begin
            if (m_hold) begin
                if (out_ready) m_hold = 0;
            end else if (in_valid) begin
                if (!m_inframe) begin
                    m_acc = x; m_cnt = 1; m_ovf = 0;
                end else begin
                    m_acc = add_model(m_acc, x, m_ovf);
                    if (m_cnt < CMAX) m_cnt++;
                end
                m_inframe = !in_last;
                if (in_last) begin
                    m_hold = 1;
                    e_data = m_acc; e_cnt = m_cnt; e_ovf = m_ovf;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(ce && !m_hold));
        chk("out_valid", 64'(out_valid), 64'(m_hold));
        if (m_hold) begin
            chk("out_data", 64'(out_data), 64'(e_data[AW-1:0]));
            chk("out_count", 64'(out_count), 64'(e_cnt[CW-1:0]));
            chk("out_ovf", 64'(out_ovf), 64'(e_ovf));
        end
    end

    task automatic beat(input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic result(input string name, input logic [AW-1:0] d,
                          input int c, input logic o);
        @(negedge clk);
        chk({name, ".valid"}, 64'(out_valid), 64'(1));
        chk({name, ".data"}, 64'(out_data), 64'(d));
        chk({name, ".count"}, 64'(out_count), 64'(c));
        chk({name, ".ovf"}, 64'(out_ovf), 64'(o));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", 64'(out_valid), 64'(0));
        chk("rst.data", 64'(out_data), 64'(0));
        chk("rst.count", 64'(out_count), 64'(0));
        chk("rst.ovf", 64'(out_ovf), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        beat(32'd3, 1'b0);
        beat(-32'sd5, 1'b0);
        beat(32'd10, 1'b1);
        result("sum3", 32'd8, 3, 1'b0);

        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'd1, 1'b1);
`ifdef EXO1_DOT_ACC_SAT_EN
        result("posovf", 32'h7FFF_FFFF, 2, 1'b1);
`else
        result("posovf", 32'h8000_0000, 2, 1'b1);
`endif

        beat(32'h8000_0000, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1);
`ifdef EXO1_DOT_ACC_SAT_EN
        result("negovf", 32'h8000_0000, 2, 1'b1);
`else
        result("negovf", 32'h7FFF_FFFF, 2, 1'b1);
`endif

        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'd1, 1'b0);
`ifdef EXO1_DOT_ACC_SAT_EN
        beat(32'hFFFF_FFFF, 1'b1);
        result("sticky", 32'h7FFF_FFFE, 3, 1'b1);
`else
        beat(32'd1, 1'b1);
        result("sticky", 32'h8000_0001, 3, 1'b1);
`endif

        beat(32'd5, 1'b0);
        beat(-32'sd2, 1'b1);
        result("ovfclr", 32'd3, 2, 1'b0);

        out_ready = 1'b0;
        beat(-32'sd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold.valid", 64'(out_valid), 64'(1));
            chk("hold.data", 64'(out_data), 64'(32'hFFFF_FFF9));
            chk("hold.count", 64'(out_count), 64'(1));
            chk("hold.in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("consume.valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        result("single", 32'd100, 1, 1'b0);

        beat(32'd4, 1'b0);
        beat(32'd4, 1'b0);
        ce = 1'b0; in_valid = 1'b1; in_data = 32'd4; in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ce_low.in_ready", 64'(in_ready), 64'(0));
            @(posedge clk);
        end
        #1;
        ce = 1'b1;
        beat(32'd4, 1'b1);
        result("ce_gap", 32'd12, 3, 1'b0);

        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst.count", 64'(out_count), 64'(0));
        chk("postrst.valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        beat(32'd9, 1'b1);
        result("after_rst", 32'd9, 1, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
